imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe.sv | 191 +++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes I/S/B/U/J immediates, sign-extends to XLEN,
// and buffers results in a 2-entry skid buffer. Define IMM_GEN_UJ_EN to enable U/J decode.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
`ifdef IMM_GEN_UJ_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
`ifdef IMM_GEN_UJ_EN
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // ---------------- decode ----------------
  logic [6:0]      opcode;
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec_entry;

  assign opcode = in_instr[6:0];

  always_comb begin
    imm32       = '0;
    dec_fmt     = FMT_R;
    dec_illegal = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_fmt = FMT_I;
      end
      OP_STORE: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt = FMT_S;
      end
      OP_BRANCH: begin
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
`ifdef IMM_GEN_UJ_EN
      OP_LUI, OP_AUIPC: begin
        imm32   = {in_instr[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      OP_JAL: begin
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
`endif
      OP_REG: begin
        imm32   = '0;
        dec_fmt = FMT_R;
      end
      default: begin
        imm32       = '0;
        dec_fmt     = FMT_R;
        dec_illegal = 1'b1;
      end
    endcase
  end

`ifndef IMM_GEN_UJ_EN
  // Only U/J immediates draw on these bits.
  logic unused_uj_bits;
  assign unused_uj_bits = ^in_instr[19:12];
`endif

  // imm32 is already sign-extended to 32 bits, so bit 31 equals instr[31].
  generate
    if (XLEN == 32) begin : g_xlen32
      assign dec_imm = imm32;
    end else begin : g_xlen_wide
      assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
    end
  endgenerate

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};

  // ---------------- skid buffer ----------------
  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = dec_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d  = dec_entry;
        end else if (accept) begin
          skid_d  = dec_entry;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Skid holds the younger entry; it advances to main on pop.
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: decode vectors, backpressure ordering, async reset.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with out_ready high: one accept, checked at the next negedge.
  task automatic push_check(input string name, input logic [31:0] instr, input logic [TAG_W-1:0] tag,
                            input logic [31:0] exp_imm, input logic [2:0] exp_fmt,
                            input logic exp_ill);
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("xfer %s instr=%08h tag=%0d -> imm=%08h fmt=%0d ill=%0b", name, instr, tag,
             out_imm, out_fmt, out_illegal);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_imm"}, 64'(out_imm), 64'(exp_imm));
    chk({name, "_fmt"}, 64'(out_fmt), 64'(exp_fmt));
    chk({name, "_ill"}, 64'(out_illegal), 64'(exp_ill));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;

    // Back-to-back decode vectors with out_ready high.
    push_check("addi", 32'hFFF00093, 5'd7, 32'hFFFFFFFF, 3'd1, 1'b0);
    push_check("sw", 32'h00112623, 5'd8, 32'h0000000C, 3'd2, 1'b0);
    push_check("beq", 32'hFE000EE3, 5'd9, 32'hFFFFFFFC, 3'd3, 1'b0);
    push_check("lw_neg", 32'h80002003, 5'd10, 32'hFFFFF800, 3'd1, 1'b0);
    push_check("jalr", 32'h00008067, 5'd11, 32'h00000000, 3'd1, 1'b0);
    push_check("add", 32'h002081B3, 5'd12, 32'h00000000, 3'd0, 1'b0);
    push_check("bad_op", 32'h0000007F, 5'd13, 32'h00000000, 3'd0, 1'b1);
`ifdef IMM_GEN_UJ_EN
    push_check("lui", 32'h123450B7, 5'd14, 32'h12345000, 3'd4, 1'b0);
    push_check("jal", 32'hFF9FF06F, 5'd15, 32'hFFFFFFF8, 3'd5, 1'b0);
`else
    push_check("lui", 32'h123450B7, 5'd14, 32'h00000000, 3'd0, 1'b1);
    push_check("jal", 32'hFF9FF06F, 5'd15, 32'h00000000, 3'd0, 1'b1);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Backpressure: tags 1,2 fill the buffer, tag 3 is held off.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00112623;
    in_tag    = 5'd1;
    @(posedge clk);
    @(negedge clk);
    $display("xfer bp accept tag=1 in_ready=%0b out_tag=%0d", in_ready, out_tag);
    chk("bp1_in_ready", 64'(in_ready), 64'd1);
    chk("bp1_tag", 64'(out_tag), 64'd1);
    in_instr = 32'hFE000EE3;
    in_tag   = 5'd2;
    @(posedge clk);
    @(negedge clk);
    $display("xfer bp accept tag=2 in_ready=%0b out_tag=%0d", in_ready, out_tag);
    chk("bp2_in_ready", 64'(in_ready), 64'd0);
    chk("bp2_tag", 64'(out_tag), 64'd1);
    in_instr = 32'hFFF00093;
    in_tag   = 5'd3;
    @(posedge clk);
    @(negedge clk);
    $display("xfer bp stall tag=3 in_ready=%0b out_tag=%0d", in_ready, out_tag);
    chk("bp3_in_ready", 64'(in_ready), 64'd0);
    chk("bp3_stable_tag", 64'(out_tag), 64'd1);
    chk("bp3_stable_imm", 64'(out_imm), 64'h0000000C);
    chk("bp3_stable_fmt", 64'(out_fmt), 64'd2);

    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("xfer drain tag=%0d imm=%08h", out_tag, out_imm);
    chk("dr2_tag", 64'(out_tag), 64'd2);
    chk("dr2_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("dr2_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("xfer drain tag=%0d imm=%08h", out_tag, out_imm);
    chk("dr3_tag", 64'(out_tag), 64'd3);
    chk("dr3_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("dr3_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("dr_empty", 64'(out_valid), 64'd0);

    // Reset while two entries are held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_tag    = 5'd4;
    @(posedge clk);
    @(negedge clk);
    in_tag = 5'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    $display("xfer async reset out_valid=%0b in_ready=%0b", out_valid, in_ready);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    push_check("post_rst", 32'h00112623, 5'd6, 32'h0000000C, 3'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
